// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types and the execute-to-memory stage payload.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // Everything the memory stage sees from one captured instruction.
    typedef struct packed {
        logic     valid;
        word_t    outport;
        logic     zero_f;
        logic     neg_f;
        word_t    rdat2;
        regbits_t wsel;
        logic     regwen;
        logic     dren;
        logic     dwen;
        logic     memtoreg;
        logic     br_taken;
        logic     ovf_exc;
        logic     halt;
        word_t    npc;
        word_t    btarget;
    } ex_mem_t;

    // BEQ/BNE resolution from the ALU zero flag; both set resolves as taken.
    function automatic logic br_decide(
        input logic beq,
        input logic bne,
        input logic zero_f
    );
        return (beq & zero_f) | (bne & ~zero_f);
    endfunction

endpackage

// File: rtl/ex_mem_reg_ret_counter.sv
// Saturating retired-instruction counter.
module ret_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Increment unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ex_mem_reg.sv
// Execute-to-memory pipeline register with branch resolution, overflow
// write suppression, sticky halt and a retired-instruction counter.
module ex_mem_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic             ex_valid,
    input  word_t            ex_outport,
    input  logic             ex_zero_f,
    input  logic             ex_neg_f,
    input  logic             ex_over_f,
    input  word_t            ex_rdat2,
    input  regbits_t         ex_wsel,
    input  logic             ex_regwen,
    input  logic             ex_dren,
    input  logic             ex_dwen,
    input  logic             ex_memtoreg,
    input  logic             ex_beq,
    input  logic             ex_bne,
    input  logic             ex_trap_ovf,
    input  logic             ex_halt,
    input  word_t            ex_npc,
    input  word_t            ex_btarget,
    output logic             mem_valid,
    output word_t            mem_outport,
    output logic             mem_zero_f,
    output logic             mem_neg_f,
    output word_t            mem_rdat2,
    output regbits_t         mem_wsel,
    output logic             mem_regwen,
    output logic             mem_dren,
    output logic             mem_dwen,
    output logic             mem_memtoreg,
    output logic             mem_br_taken,
    output logic             mem_ovf_exc,
    output logic             mem_halt,
    output word_t            mem_npc,
    output word_t            mem_btarget,
    output logic [CNT_W-1:0] retired
);

    ex_mem_t stage_q;
    ex_mem_t stage_d;
    logic    ovf_c;
    logic    cnt_inc_c;

    // Next stage contents: halt freezes, flush bubbles, en captures with gating.
    always_comb begin
        stage_d   = stage_q;
        cnt_inc_c = 1'b0;
        ovf_c     = ex_valid & ex_trap_ovf & ex_over_f;
        if (!stage_q.halt) begin
            if (flush) begin
                stage_d = '0;
            end else if (en) begin
                stage_d.valid    = ex_valid;
                stage_d.outport  = ex_outport;
                stage_d.zero_f   = ex_zero_f;
                stage_d.neg_f    = ex_neg_f;
                stage_d.rdat2    = ex_rdat2;
                stage_d.wsel     = ex_wsel;
                stage_d.memtoreg = ex_memtoreg;
                stage_d.npc      = ex_npc;
                stage_d.btarget  = ex_btarget;
                stage_d.regwen   = ex_valid & ex_regwen & ~ovf_c;
                stage_d.dwen     = ex_valid & ex_dwen & ~ovf_c;
                stage_d.dren     = ex_valid & ex_dren;
                stage_d.ovf_exc  = ovf_c;
                stage_d.br_taken = ex_valid & br_decide(ex_beq, ex_bne, ex_zero_f);
                stage_d.halt     = ex_valid & ex_halt;
                cnt_inc_c        = ex_valid;
            end
        end
    end

    // Stage register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    ret_counter #(
        .CNT_W (CNT_W)
    ) u_ret_counter (
        .clk     (CLK),
        .rst     (RST),
        .inc     (cnt_inc_c),
        .count_o (retired)
    );

    assign mem_valid    = stage_q.valid;
    assign mem_outport  = stage_q.outport;
    assign mem_zero_f   = stage_q.zero_f;
    assign mem_neg_f    = stage_q.neg_f;
    assign mem_rdat2    = stage_q.rdat2;
    assign mem_wsel     = stage_q.wsel;
    assign mem_regwen   = stage_q.regwen;
    assign mem_dren     = stage_q.dren;
    assign mem_dwen     = stage_q.dwen;
    assign mem_memtoreg = stage_q.memtoreg;
    assign mem_br_taken = stage_q.br_taken;
    assign mem_ovf_exc  = stage_q.ovf_exc;
    assign mem_halt     = stage_q.halt;
    assign mem_npc      = stage_q.npc;
    assign mem_btarget  = stage_q.btarget;

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Execute-to-memory pipeline register for the pipelined MIPS core. It captures the ALU result, ALU flags, store data and memory/writeback control at the end of the execute stage. It resolves BEQ/BNE from the captured zero flag and suppresses architectural writes for trapping arithmetic that overflowed. It also provides a sticky halt and a retired-instruction counter to the memory stage and hazard logic.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- en  in  1  advance: capture execute-stage values this edge
- flush  in  1  insert bubble this edge
- ex_valid  in  1  execute stage holds a real instruction
- ex_outport  in  32  ALU result
- ex_zero_f, ex_neg_f, ex_over_f  in  1 each  ALU flags
- ex_rdat2  in  32  store data
- ex_wsel  in  5  destination register
- ex_regwen, ex_dren, ex_dwen, ex_memtoreg  in  1 each  writeback/memory controls
- ex_beq, ex_bne  in  1 each  branch type
- ex_trap_ovf  in  1  instruction is signed ADD/SUB (overflow traps)
- ex_halt  in  1  HALT instruction
- ex_npc, ex_btarget  in  32 each  PC+4 and branch target
- mem_valid, mem_outport, mem_rdat2, mem_wsel, mem_regwen, mem_dren, mem_dwen, mem_memtoreg, mem_npc, mem_btarget  out  (widths as inputs)  registered copies
- mem_zero_f, mem_neg_f  out  1  registered flags
- mem_br_taken  out  1  registered branch decision
- mem_ovf_exc  out  1  captured instruction overflowed and was suppressed
- mem_halt  out  1  sticky halt
- retired  out  CNT_W  count of valid instructions captured

## Operation
- Per-edge priority: RST > halted-freeze > flush > en > hold.
- RST: every output is 0, including mem_halt and retired.
- Halted (mem_halt=1): all registers frozen; en and flush are ignored until RST.
- flush=1: mem_valid=0. All control outputs (regwen, dren, dwen, memtoreg, br_taken, ovf_exc, halt) are 0. Data outputs are 0. retired is unchanged.
- en=1, flush=0: all data fields are copied from ex_*. mem_valid=ex_valid. Control outputs are gated:
  - ovf = ex_valid & ex_trap_ovf & ex_over_f
  - mem_regwen = ex_valid & ex_regwen & ~ovf
  - mem_dwen = ex_valid & ex_dwen & ~ovf
  - mem_dren = ex_valid & ex_dren
  - mem_ovf_exc = ovf
  - mem_br_taken = ex_valid & ((ex_beq & ex_zero_f) | (ex_bne & ~ex_zero_f))
  - mem_halt = ex_valid & ex_halt
- en=0, flush=0: all registers hold.
- retired increments by 1 on each en capture with ex_valid=1 and flush=0. It saturates at 2^CNT_W−1 and does not wrap.
- ex_beq and ex_bne both 1 is illegal. Behaviour is defined by the formula above, which gives taken=1.

## Timing
- Latency is exactly 1 cycle, ex_* to mem_*. There is no combinational path from any input to any output.
- mem_br_taken is valid in the cycle after capture. The hazard unit uses it to redirect the PC and flush the younger stages.
- The halt capture edge sets mem_halt. From the next edge onward, state is frozen.
- Asserting RST mid-stall or mid-flush clears everything on that edge, and the register is empty in the following cycle.

## Structure
- cpu_types_pkg holds word_t (32-bit) and regbits_t (5-bit). All ports use these types where applicable.
- Bundle the ports into an ex_mem_if interface with modports for execute, memory, and the hazard unit.
- Sub-module ret_counter: saturating counter with reset, inc and CNT_W parameter.
- All other logic is one registered block plus gating logic.

## Test plan
- Reset check: RST=1 with arbitrary inputs. All outputs are 0. Release RST, en=1 with ex_valid=1, ex_outport=0x0000_0010: next cycle mem_outport=0x10, retired=1.
- Overflow trap: ADD with ex_trap_ovf=1, ex_over_f=1, ex_regwen=1, en=1 → mem_regwen=0, mem_ovf_exc=1, mem_outport=0x8000_0000 passed through. The same case with ex_trap_ovf=0 gives mem_regwen=1.
- Branch decision: ex_beq=1, ex_zero_f=1 → mem_br_taken=1. ex_bne=1, ex_zero_f=1 → 0. ex_bne=1, ex_zero_f=0, ex_valid=0 → 0.
- Stall and flush: capture 0xDEAD_BEEF, then en=0 for 3 cycles. Output holds and retired holds. Then en=1 with flush=1: mem_valid=0, all controls 0, retired unchanged.
- Halt freeze: capture HALT (ex_valid=1, ex_halt=1). mem_halt=1. Subsequent en=1 with new data and flush=1 change nothing. RST clears it.
- Counter saturation with CNT_W=4: 17 valid captures → retired reaches 15 and holds at 15.
